// File: rtl/bus_arbiter8_pkg.sv
// Shared types and sizes for the 8-way round-robin bus arbiter.
package bus_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Rotating-priority search: first set bit of req at or above base, wrapping 7->0.
module bus_arb_pick
    import bus_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   base,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_cand;

    assign found = |req;

    // Walk from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        idx    = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = base + SEL_W'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter8.sv
// 8-requester round-robin arbiter with bounded tenure and a one-cycle turnaround.
//   state | meaning
//   IDLE  | evaluate req at each edge; grant the round-robin winner
//   GRANT | owner holds the bus; burst_cnt counts granted cycles
//   TURN  | one dead cycle after a tenure; req not evaluated
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               bus_valid,
    output logic [CNT_W-1:0]   burst_cnt
);

    arb_state_t         r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic               r_valid, w_valid_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;

    bus_arb_pick u_pick (
        .req   (req),
        .base  (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt        = GRANT;
                    w_gnt_nxt          = '0;
                    w_gnt_nxt[w_idx]   = 1'b1;
                    w_sel_nxt          = w_idx;
                    w_valid_nxt        = 1'b1;
                    w_cnt_nxt          = CNT_W'(1);
                    w_ptr_nxt          = w_idx + SEL_W'(1);
                end
            end
            GRANT: begin
                // Owner release and forced release share one exit path.
                if (!req[r_sel] || (r_cnt == CNT_W'(MAX_BURST))) begin
                    w_state_nxt = TURN;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            TURN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign bus_valid = r_valid;
    assign burst_cnt = r_cnt;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8 with MAX_BURST=4; expected values written by hand.
module tb_bus_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       bus_valid;
    logic [3:0] burst_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter8 #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_sel,
                             input logic e_valid, input logic [3:0] e_cnt);
        check({tag, " gnt"}, gnt, e_gnt);
        check({tag, " sel"}, {5'd0, sel}, {5'd0, e_sel});
        check({tag, " bus_valid"}, {7'd0, bus_valid}, {7'd0, e_valid});
        check({tag, " burst_cnt"}, {4'd0, burst_cnt}, {4'd0, e_cnt});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Granted cycles first..last of a tenure by owner.
    task automatic expect_burst(input int owner, input int first, input int last);
        logic [7:0] e_gnt;
        e_gnt = 8'd1 << owner;
        for (int c = first; c <= last; c++) begin
            step();
            check_out($sformatf("grant o%0d c%0d", owner, c), e_gnt, owner[2:0], 1'b1, c[3:0]);
        end
    endtask

    task automatic turn_idle(input int owner);
        step();
        check_out($sformatf("turn o%0d", owner), 8'h00, owner[2:0], 1'b0, 4'd0);
        step();
        check_out($sformatf("idle o%0d", owner), 8'h00, owner[2:0], 1'b0, 4'd0);
    endtask

    // Continuous structural invariants on the outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
            check("inv valid", {7'd0, bus_valid}, {7'd0, |gnt});
            if (bus_valid) check("inv gnt_sel", {7'd0, gnt[sel]}, 8'd1);
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 8'h00, 3'd0, 1'b0, 4'd0);
        rst_n = 1'b1;

        // Single request, owner drops after two granted cycles.
        req = 8'h08;
        expect_burst(3, 1, 2);
        req = 8'h00;
        turn_idle(3);
        step();
        check_out("stay idle", 8'h00, 3'd3, 1'b0, 4'd0);

        // Fresh reset so requester 0 leads, then all requesters held.
        rst_n = 1'b0;
        @(negedge clk);
        check_out("reset2", 8'h00, 3'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            expect_burst(k % 8, 1, 4);
            turn_idle(k % 8);
        end
        req = 8'h00;

        // ptr is 1; owner 5 moves ptr to 6, then 6 -> 0 -> 1 across the wrap.
        req = 8'h20;
        expect_burst(5, 1, 1);
        req = 8'h00;
        turn_idle(5);
        req = 8'h43;
        expect_burst(6, 1, 4);
        turn_idle(6);
        expect_burst(0, 1, 4);
        turn_idle(0);
        expect_burst(1, 1, 4);
        req = 8'h00;
        turn_idle(1);

        // Owner drops req in the same cycle the burst limit is reached.
        req = 8'h04;
        expect_burst(2, 1, 4);
        req = 8'h00;
        turn_idle(2);
        step();
        check_out("sim exit idle", 8'h00, 3'd2, 1'b0, 4'd0);

        // Forced release: lone requester wins again; a later non-owner request wins after.
        req = 8'h08;
        expect_burst(3, 1, 4);
        turn_idle(3);
        expect_burst(3, 1, 1);
        req = 8'h0A;
        expect_burst(3, 2, 4);
        turn_idle(3);
        expect_burst(1, 1, 1);
        req = 8'h00;
        turn_idle(1);

        // Reset mid-tenure of owner 5, then requester 0 leads again.
        req = 8'h20;
        expect_burst(5, 1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async reset", 8'h00, 3'd0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h21;
        expect_burst(0, 1, 1);
        req = 8'h00;
        turn_idle(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 Parameter MAX_BURST, default 4, range 1..15: maximum consecutive granted cycles per tenure.
REQ-002 clk  input  1  the single clock; all state on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  level request; bit i = requester i; held high for the whole tenure.
REQ-005 gnt  output  8  one-hot grant, bit i = requester i; all-zero when no tenure is active.
REQ-006 sel  output  3  binary index of the current owner, for the shared mux8to1 select.
REQ-007 bus_valid  output  1  high exactly when gnt is non-zero.
REQ-008 burst_cnt  output  4  granted cycles elapsed in the current tenure (1..MAX_BURST), 0 when idle.

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT and TURN (one-cycle turnaround).
REQ-010 IDLE: if req is non-zero at a rising edge, the block SHALL enter GRANT and register the winner; otherwise it SHALL stay in IDLE.
REQ-011 Latency SHALL be one cycle: req sampled at edge N drives gnt, sel, bus_valid and burst_cnt=1 after edge N.
REQ-012 Winner selection SHALL be round-robin: search req from index ptr upward, wrapping 7->0; the first set bit wins.
REQ-013 On every grant, ptr SHALL load (winner+1) mod 8, so the winner has lowest priority next time.
REQ-014 GRANT: gnt, sel and bus_valid SHALL stay constant, and burst_cnt SHALL increment by 1 each cycle.
REQ-015 GRANT SHALL exit to TURN at the edge where req[owner]=0, or where burst_cnt==MAX_BURST (forced release), whichever comes first.
REQ-016 If both exit conditions occur in the same cycle, the block SHALL make a single transition to TURN with no difference in behaviour.
REQ-017 TURN SHALL last exactly one cycle with gnt=0, bus_valid=0 and burst_cnt=0, then go to IDLE; requests are not evaluated in TURN.
REQ-018 A forced-released requester that keeps req high SHALL be re-arbitrated normally and SHALL win again only if no other request is pending from ptr onward.
REQ-019 Requests from non-owners during GRANT SHALL be ignored until the next IDLE evaluation; they SHALL not be latched.
REQ-020 sel SHALL hold the last owner index while idle or in TURN; consumers SHALL qualify sel with bus_valid.
REQ-021 gnt SHALL never have more than one bit set; this is checked by an assertion.
REQ-022 All outputs SHALL be registered, with no combinational path from req to any output.
REQ-023 Worst-case wait for a requester holding req high SHALL be bounded by 7*(MAX_BURST+2)+1 cycles.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, gnt=0, sel=0, bus_valid=0, burst_cnt=0 and ptr=0.
REQ-025 Reset asserted mid-tenure SHALL drop the grant immediately, with no TURN cycle.
REQ-026 After reset, requester 0 SHALL hold top priority.
REQ-027 The first grant after rst_n rises SHALL follow REQ-010 and REQ-011 with no additional delay.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE, GRANT, TURN), NUM_REQ=8, SEL_W=3 and CNT_W=4.
REQ-029 One combinational sub-module, bus_arb_pick, SHALL take inputs req[7:0] and base[2:0] and produce outputs found and idx[2:0] (rotating priority search).
REQ-030 bus_arbiter8 SHALL instantiate bus_arb_pick once and contain only the FSM, ptr, counter and output registers.

Verification
REQ-031 Single request: req=8'h08 from IDLE -> gnt=8'h08, sel=3, bus_valid=1 one cycle later; req drops after 2 granted cycles -> one TURN cycle, then IDLE.
REQ-032 Round-robin: req=8'hFF held, MAX_BURST=4 -> owners 0,1,2,...,7,0, each for 4 cycles followed by one TURN cycle.
REQ-033 Wrap: ptr=6 with req=8'h03|8'h40 -> owner 6, then 0, then 1.
REQ-034 Simultaneous exit: the owner drops req in the cycle burst_cnt==MAX_BURST -> exactly one TURN cycle, with no glitch on gnt.
REQ-035 Reset mid-tenure: rst_n low during GRANT of owner 5 -> gnt=0 asynchronously; after release with req=8'h21 -> owner 0.
REQ-036 Every scenario SHALL check continuously that gnt is one-hot or zero, bus_valid==|gnt, and gnt[sel]==1 whenever bus_valid=1.
